// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported unified RAM between instruction fetch (imem side)
//   and the memory stage (dmem side). Stores are captured into a one-entry
//   buffer and drained ahead of loads, which gives read-after-write ordering.
//   Data-side traffic has priority. Fetch is forced through after
//   STARVE_LIMIT consecutive data grants have passed it by.
//   Only one RAM transaction is outstanding at a time.
//
// Ports
//   clk, reset       rising-edge clock, asynchronous active-high reset
//   imem_*           fetch read request (held until imem_rd_ready) and response
//   mem_addr         dmem address for loads and stores
//   mem_rd_*         load request (held until mem_rd_ready) and response
//   mem_wr_*         one-cycle store pulse with data and size (00 B, 01 H, 10 W)
//   wb_full          store buffer occupied
//   wb_overflow      sticky: a store was dropped because the buffer was full
//   ram_*            RAM side: one-cycle write strobe, read held until ram_rd_valid
module mem_port_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rd_enable,
    output logic [DATA_W-1:0] imem_rd_data,
    output logic              imem_rd_ready,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rd_enable,
    output logic [DATA_W-1:0] mem_rd_data,
    output logic              mem_rd_ready,
    input  logic              mem_wr_enable,
    input  logic [DATA_W-1:0] mem_wr_data,
    input  logic [1:0]        mem_wr_size,
    output logic              wb_full,
    output logic              wb_overflow,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wr_enable,
    output logic [DATA_W-1:0] ram_wr_data,
    output logic [1:0]        ram_wr_size,
    output logic              ram_rd_enable,
    input  logic [DATA_W-1:0] ram_rd_data,
    input  logic              ram_rd_valid
);

    localparam int unsigned       CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, WR, RD_D, RD_I} state_t;

    state_t            state, state_next;
    logic [CNT_W-1:0]  starve_cnt, starve_cnt_next;
    logic              flushed, flushed_next;
    logic [ADDR_W-1:0] wb_addr, wb_addr_next;
    logic [DATA_W-1:0] wb_data, wb_data_next;
    logic [1:0]        wb_size, wb_size_next;
    logic              wb_full_next, wb_overflow_next;

    logic [DATA_W-1:0] imem_rd_data_next, mem_rd_data_next, ram_wr_data_next;
    logic              imem_rd_ready_next, mem_rd_ready_next;
    logic [ADDR_W-1:0] ram_addr_next;
    logic              ram_wr_enable_next, ram_rd_enable_next;
    logic [1:0]        ram_wr_size_next;

    logic imem_req, mem_req, starved;
    logic grant_data, grant_imem, wb_drain;

    // A requester whose ready pulse is high is still holding the enable of the
    // read that just finished; treating that as a fresh request would repeat it.
    assign imem_req = imem_rd_enable && !imem_rd_ready;
    assign mem_req  = mem_rd_enable && !mem_rd_ready;
    assign starved  = (starve_cnt == LIMIT) && imem_req;

    always_comb begin
        state_next         = state;
        flushed_next       = flushed;
        starve_cnt_next    = starve_cnt;
        imem_rd_data_next  = imem_rd_data;
        mem_rd_data_next   = mem_rd_data;
        imem_rd_ready_next = 1'b0;
        mem_rd_ready_next  = 1'b0;
        ram_addr_next      = ram_addr;
        ram_wr_enable_next = 1'b0;
        ram_wr_data_next   = ram_wr_data;
        ram_wr_size_next   = ram_wr_size;
        ram_rd_enable_next = ram_rd_enable;
        wb_addr_next       = wb_addr;
        wb_data_next       = wb_data;
        wb_size_next       = wb_size;
        wb_full_next       = wb_full;
        wb_overflow_next   = wb_overflow;
        grant_data         = 1'b0;
        grant_imem         = 1'b0;
        wb_drain           = 1'b0;

        case (state)
            IDLE: begin
                if (starved) begin
                    grant_imem = 1'b1;
                end else if (wb_full) begin
                    grant_data         = 1'b1;
                    state_next         = WR;
                    ram_wr_enable_next = 1'b1;
                    ram_addr_next      = wb_addr;
                    ram_wr_data_next   = wb_data;
                    ram_wr_size_next   = wb_size;
                end else if (mem_req) begin
                    grant_data         = 1'b1;
                    state_next         = RD_D;
                    ram_rd_enable_next = 1'b1;
                    ram_addr_next      = mem_addr;
                    flushed_next       = 1'b0;
                end else if (imem_req) begin
                    grant_imem = 1'b1;
                end
                if (grant_imem) begin
                    state_next         = RD_I;
                    ram_rd_enable_next = 1'b1;
                    ram_addr_next      = imem_addr;
                    flushed_next       = 1'b0;
                end
            end
            WR: begin
                wb_drain   = 1'b1;
                state_next = IDLE;
            end
            RD_D: begin
                // Once the enable drops the read is abandoned, even if re-raised.
                if (!mem_rd_enable) flushed_next = 1'b1;
                if (ram_rd_valid) begin
                    ram_rd_enable_next = 1'b0;
                    state_next         = IDLE;
                    if (mem_rd_enable && !flushed) begin
                        mem_rd_data_next  = ram_rd_data;
                        mem_rd_ready_next = 1'b1;
                    end
                end
            end
            RD_I: begin
                if (!imem_rd_enable) flushed_next = 1'b1;
                if (ram_rd_valid) begin
                    ram_rd_enable_next = 1'b0;
                    state_next         = IDLE;
                    if (imem_rd_enable && !flushed) begin
                        imem_rd_data_next  = ram_rd_data;
                        imem_rd_ready_next = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        if (!imem_rd_enable) begin
            starve_cnt_next = '0;
        end else if (grant_imem) begin
            starve_cnt_next = '0;
        end else if (grant_data && (starve_cnt != LIMIT)) begin
            starve_cnt_next = starve_cnt + CNT_W'(1);
        end

        // A drain completing this cycle frees the slot for a same-cycle store.
        if (wb_drain) wb_full_next = 1'b0;
        if (mem_wr_enable) begin
            if (!wb_full || wb_drain) begin
                wb_full_next = 1'b1;
                wb_addr_next = mem_addr;
                wb_data_next = mem_wr_data;
                wb_size_next = mem_wr_size;
            end else begin
                wb_overflow_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            flushed       <= 1'b0;
            starve_cnt    <= '0;
            imem_rd_data  <= '0;
            mem_rd_data   <= '0;
            imem_rd_ready <= 1'b0;
            mem_rd_ready  <= 1'b0;
            ram_addr      <= '0;
            ram_wr_enable <= 1'b0;
            ram_wr_data   <= '0;
            ram_wr_size   <= '0;
            ram_rd_enable <= 1'b0;
            wb_addr       <= '0;
            wb_data       <= '0;
            wb_size       <= '0;
            wb_full       <= 1'b0;
            wb_overflow   <= 1'b0;
        end else begin
            state         <= state_next;
            flushed       <= flushed_next;
            starve_cnt    <= starve_cnt_next;
            imem_rd_data  <= imem_rd_data_next;
            mem_rd_data   <= mem_rd_data_next;
            imem_rd_ready <= imem_rd_ready_next;
            mem_rd_ready  <= mem_rd_ready_next;
            ram_addr      <= ram_addr_next;
            ram_wr_enable <= ram_wr_enable_next;
            ram_wr_data   <= ram_wr_data_next;
            ram_wr_size   <= ram_wr_size_next;
            ram_rd_enable <= ram_rd_enable_next;
            wb_addr       <= wb_addr_next;
            wb_data       <= wb_data_next;
            wb_size       <= wb_size_next;
            wb_full       <= wb_full_next;
            wb_overflow   <= wb_overflow_next;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter. A behavioural RAM answers reads after
//   a programmable latency: ram_rd_valid is raised `lat` cycles after the first
//   cycle ram_rd_enable is seen. Word i of the RAM initially holds 0xA0000000+i.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic        imem_rd_enable;
    logic [31:0] imem_rd_data;
    logic        imem_rd_ready;
    logic [31:0] mem_addr;
    logic        mem_rd_enable;
    logic [31:0] mem_rd_data;
    logic        mem_rd_ready;
    logic        mem_wr_enable;
    logic [31:0] mem_wr_data;
    logic [1:0]  mem_wr_size;
    logic        wb_full;
    logic        wb_overflow;
    logic [31:0] ram_addr;
    logic        ram_wr_enable;
    logic [31:0] ram_wr_data;
    logic [1:0]  ram_wr_size;
    logic        ram_rd_enable;
    logic [31:0] ram_rd_data  = '0;
    logic        ram_rd_valid = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    int lat      = 1;

    logic [31:0] ram [256];
    logic        ram_loaded = 1'b0;
    int          rd_cnt     = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .STARVE_LIMIT(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .imem_addr(imem_addr),
        .imem_rd_enable(imem_rd_enable),
        .imem_rd_data(imem_rd_data),
        .imem_rd_ready(imem_rd_ready),
        .mem_addr(mem_addr),
        .mem_rd_enable(mem_rd_enable),
        .mem_rd_data(mem_rd_data),
        .mem_rd_ready(mem_rd_ready),
        .mem_wr_enable(mem_wr_enable),
        .mem_wr_data(mem_wr_data),
        .mem_wr_size(mem_wr_size),
        .wb_full(wb_full),
        .wb_overflow(wb_overflow),
        .ram_addr(ram_addr),
        .ram_wr_enable(ram_wr_enable),
        .ram_wr_data(ram_wr_data),
        .ram_wr_size(ram_wr_size),
        .ram_rd_enable(ram_rd_enable),
        .ram_rd_data(ram_rd_data),
        .ram_rd_valid(ram_rd_valid)
    );

    // RAM model, evaluated mid-cycle so the DUT sees stable inputs at posedge.
    always @(negedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < 256; i++) ram[i] = 32'hA000_0000 + 32'(i);
            ram_loaded = 1'b1;
        end
        if (ram_wr_enable) ram[ram_addr[9:2]] = ram_wr_data;
        if (ram_rd_valid) begin
            ram_rd_valid = 1'b0;
            rd_cnt       = 0;
        end else if (ram_rd_enable) begin
            rd_cnt++;
            if (rd_cnt == lat + 1) begin
                ram_rd_data  = ram[ram_addr[9:2]];
                ram_rd_valid = 1'b1;
            end
        end else begin
            rd_cnt = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic store_pulse(input logic [31:0] a, input logic [31:0] d);
        mem_wr_enable = 1'b1;
        mem_addr      = a;
        mem_wr_data   = d;
        mem_wr_size   = 2'b10;
    endtask

    initial begin
        int first, pulses, wr_cyc, rd_cyc, rdy_cyc, late_wr, wr_before;
        logic [31:0] wr_addr, wr_data, rd_addr;
        logic [1:0]  wr_size;
        logic        full4, ovf4, full8, ovf8, full_at_rd;

        reset          = 1'b1;
        imem_addr      = '0;
        imem_rd_enable = 1'b0;
        mem_addr       = '0;
        mem_rd_enable  = 1'b0;
        mem_wr_enable  = 1'b0;
        mem_wr_data    = '0;
        mem_wr_size    = '0;
        repeat (3) tick();
        reset = 1'b0;

        // Reset state
        check("rst_imem_rd_data",  imem_rd_data, 32'h0);
        check("rst_imem_rd_ready", 32'(imem_rd_ready), 32'h0);
        check("rst_mem_rd_data",   mem_rd_data, 32'h0);
        check("rst_mem_rd_ready",  32'(mem_rd_ready), 32'h0);
        check("rst_wb_full",       32'(wb_full), 32'h0);
        check("rst_wb_overflow",   32'(wb_overflow), 32'h0);
        check("rst_ram_addr",      ram_addr, 32'h0);
        check("rst_ram_wr_enable", 32'(ram_wr_enable), 32'h0);
        check("rst_ram_wr_data",   ram_wr_data, 32'h0);
        check("rst_ram_wr_size",   32'(ram_wr_size), 32'h0);
        check("rst_ram_rd_enable", 32'(ram_rd_enable), 32'h0);
        tick();
        check("idle_ram_rd_enable", 32'(ram_rd_enable), 32'h0);

        // Fetch 0x100 alone, latency 3: ready at cycle 2+3
        lat = 3;
        imem_addr = 32'h100;
        imem_rd_enable = 1'b1;
        first = 0; pulses = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 1) begin
                check("fetch_ram_rd_enable_c1", 32'(ram_rd_enable), 32'h1);
                check("fetch_ram_addr", ram_addr, 32'h100);
            end
            if (imem_rd_ready) begin
                pulses++;
                if (first == 0) first = k;
                imem_rd_enable = 1'b0;
            end
        end
        check("fetch_ready_cycle", first, 5);
        check("fetch_ready_pulses", pulses, 1);
        check("fetch_data", imem_rd_data, 32'hA000_0040);

        // Store then load of the same word: store drains first
        lat = 2;
        store_pulse(32'h40, 32'hDEAD_BEEF);
        wr_cyc = 0; rd_cyc = 0; rdy_cyc = 0;
        wr_data = '0; wr_size = '0;
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (k == 1) begin
                mem_wr_enable = 1'b0;
                mem_rd_enable = 1'b1;
            end
            if (ram_wr_enable && wr_cyc == 0) begin
                wr_cyc = k; wr_data = ram_wr_data; wr_size = ram_wr_size;
            end
            if (ram_rd_enable && rd_cyc == 0) rd_cyc = k;
            if (mem_rd_ready && rdy_cyc == 0) begin
                rdy_cyc = k;
                mem_rd_enable = 1'b0;
            end
        end
        check("raw_wr_cycle", wr_cyc, 2);
        check("raw_rd_cycle", rd_cyc, 4);
        check("raw_ready_cycle", rdy_cyc, 7);
        check("raw_wr_data", wr_data, 32'hDEAD_BEEF);
        check("raw_wr_size", 32'(wr_size), 32'h2);
        check("raw_load_data", mem_rd_data, 32'hDEAD_BEEF);

        // Two store pulses during RD_I: first buffered, second dropped
        lat = 4;
        imem_addr = 32'h104;
        imem_rd_enable = 1'b1;
        wr_cyc = 0; rdy_cyc = 0; wr_addr = '0; wr_data = '0;
        full4 = 1'b0; ovf4 = 1'b0; full8 = 1'b1; ovf8 = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 2) store_pulse(32'h80, 32'h1111_1111);
            if (k == 3) store_pulse(32'h84, 32'h2222_2222);
            if (k == 4) mem_wr_enable = 1'b0;
            if (k == 4) begin full4 = wb_full; ovf4 = wb_overflow; end
            if (k == 8) begin full8 = wb_full; ovf8 = wb_overflow; end
            if (imem_rd_ready && rdy_cyc == 0) begin
                rdy_cyc = k;
                imem_rd_enable = 1'b0;
            end
            if (ram_wr_enable && wr_cyc == 0) begin
                wr_cyc = k; wr_addr = ram_addr; wr_data = ram_wr_data;
            end
        end
        check("ovf_full_during_read", 32'(full4), 32'h1);
        check("ovf_flag_set", 32'(ovf4), 32'h1);
        check("ovf_fetch_ready_cycle", rdy_cyc, 6);
        check("ovf_fetch_data", imem_rd_data, 32'hA000_0041);
        check("ovf_drain_cycle", wr_cyc, 7);
        check("ovf_drain_addr", wr_addr, 32'h80);
        check("ovf_drain_data", wr_data, 32'h1111_1111);
        check("ovf_full_after_drain", 32'(full8), 32'h0);
        check("ovf_flag_sticky", 32'(ovf8), 32'h1);

        // Starvation: fetch held while stores keep the data side busy
        lat = 1;
        store_pulse(32'h200, 32'h5000_0000);
        wr_before = 0; rd_cyc = 0; rdy_cyc = 0; late_wr = 0;
        rd_addr = '0; full_at_rd = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 2 || k == 4 || k == 6 || k == 8)
                store_pulse(32'h200 + 32'(4 * k), 32'h5000_0000 + 32'(k));
            else
                mem_wr_enable = 1'b0;
            if (k == 1) begin
                imem_addr = 32'h108;
                imem_rd_enable = 1'b1;
            end
            if (ram_wr_enable && rd_cyc == 0) wr_before++;
            if (ram_rd_enable && rd_cyc == 0) begin
                rd_cyc = k; rd_addr = ram_addr; full_at_rd = wb_full;
            end
            if (ram_wr_enable && k > 9 && late_wr == 0) late_wr = k;
            if (imem_rd_ready && rdy_cyc == 0) begin
                rdy_cyc = k;
                imem_rd_enable = 1'b0;
            end
        end
        check("starve_data_grants", wr_before, 4);
        check("starve_fetch_grant_cycle", rd_cyc, 10);
        check("starve_fetch_addr", rd_addr, 32'h108);
        check("starve_store_waiting", 32'(full_at_rd), 32'h1);
        check("starve_fetch_ready_cycle", rdy_cyc, 12);
        check("starve_fetch_data", imem_rd_data, 32'hA000_0042);
        check("starve_late_store_cycle", late_wr, 13);

        // Load flushed after one cycle in RD_D; fetch behind it is serviced
        lat = 2;
        mem_addr = 32'h0C;
        mem_rd_enable = 1'b1;
        pulses = 0; rdy_cyc = 0;
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (k == 2) begin
                mem_rd_enable = 1'b0;
                imem_addr = 32'h110;
                imem_rd_enable = 1'b1;
            end
            if (mem_rd_ready) pulses++;
            if (imem_rd_ready && rdy_cyc == 0) begin
                rdy_cyc = k;
                imem_rd_enable = 1'b0;
            end
        end
        check("flush_no_mem_ready", pulses, 0);
        check("flush_mem_data_held", mem_rd_data, 32'hDEAD_BEEF);
        check("flush_fetch_ready_cycle", rdy_cyc, 8);
        check("flush_fetch_data", imem_rd_data, 32'hA000_0044);

        // Reset in the middle of RD_D
        lat = 3;
        mem_addr = 32'h10;
        mem_rd_enable = 1'b1;
        tick();
        check("midrst_in_read", 32'(ram_rd_enable), 32'h1);
        tick();
        reset = 1'b1;
        mem_rd_enable = 1'b0;
        tick();
        reset = 1'b0;
        check("midrst_ram_rd_enable", 32'(ram_rd_enable), 32'h0);
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (mem_rd_ready || ram_rd_enable || ram_wr_enable) pulses++;
        end
        check("midrst_no_activity", pulses, 0);
        check("midrst_overflow_cleared", 32'(wb_overflow), 32'h0);
        check("midrst_mem_data_cleared", mem_rd_data, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
